hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It owns every write-enable and flush that decides when the IF program counter advances: PCWrite into the IF stage, plus the IF/ID and ID/EX register controls. It resolves load-use hazards, branch/jump redirects and instruction/data memory wait states. It also keeps a consecutive-stall watchdog and a stall-cycle performance counter. It sits beside the pipeline, taking decode/execute fields and memory ready lines, and drives enables into IF, the IF/ID register, the ID/EX register and the EX/MEM/WB registers.

## Interface
- REG_W, 5, register-index width
- TIMEOUT, 255, consecutive stall cycles before `stall_timeout` asserts (1..2^CNT_W-1)
- CNT_W, 8, width of the consecutive-stall counter
- clk  in  1  rising-edge clock; one clock domain
- reset  in  1  reset is synchronous and active-high
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads rs1 / rs2
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_redirect  in  1  a taken branch or jump resolved in EX this cycle
- imem_ready  in  1  the instruction fetch completes this cycle
- mem_req  in  1  the MEM stage issues a data access this cycle
- dmem_ready  in  1  the data access completes this cycle
- PCWrite  out  1  the IF PC loads IF_NPC at the next edge
- npc_sel  out  1  1 = IF_NPC takes the EX redirect target, 0 = sequential
- ifid_write, ifid_flush  out  1  IF/ID hold (write=0) / insert bubble
- idex_flush  out  1  ID/EX insert bubble
- pipe_hold  out  1  freeze EX/MEM and MEM/WB registers
- stall_timeout  out  1  sticky watchdog flag
- stall_cycles  out  32  total cycles with PCWrite=0 since reset; wraps

## Operation
- FSM states: RUN, DWAIT, IWAIT. The state register is updated on `clk`. All enable outputs are combinational in the current state and current inputs.
- Conditions:
  - dwait = mem_req & ~dmem_ready
  - lu = ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))
  - iwait = ~imem_ready
- Priority, highest first: reset > dwait > ex_redirect > lu > iwait > run.
- dwait (any state): everything holds.
  - pipe_hold=1, PCWrite=0, ifid_write=0, no flushes.
  - Next state DWAIT while dwait persists; RUN when it clears.
- ex_redirect:
  - PCWrite=1, npc_sel=1, ifid_flush=1, idex_flush=1, ifid_write=1.
  - Discards the 2 younger instructions.
  - Also overrides a pending iwait: the stale fetch is dropped.
  - Next state RUN.
- lu: PCWrite=0, ifid_write=0, idex_flush=1. This is exactly one bubble, because the load has advanced to MEM by the next cycle.
- iwait: PCWrite=0, ifid_write=0, idex_flush=1 (bubble into ID/EX). Next state IWAIT until imem_ready=1.
- run: PCWrite=1, ifid_write=1, npc_sel=0, all flushes 0, pipe_hold=0.
- ex_rd == 0 never creates a load-use stall.
- Consecutive-stall counter:
  - Increments when PCWrite=0 and saturates at 2^CNT_W-1.
  - Clears on any cycle with PCWrite=1.
  - stall_timeout sets when the counter reaches TIMEOUT and stays set until reset.
- stall_cycles increments each cycle PCWrite=0 (reset cycles excluded) and wraps modulo 2^32.

## Timing
- Control path is zero latency: a hazard presented in cycle t affects enables in cycle t, sampled at the t→t+1 edge.
- Reset behaviour while reset=1:
  - PCWrite=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, npc_sel=0.
  - At the edge: state←RUN; counter, stall_timeout and stall_cycles ← 0.
  - The first non-reset cycle behaves as RUN.
- Reset asserted mid-wait abandons DWAIT/IWAIT immediately; no pending redirect is remembered.
- Simultaneous dwait + ex_redirect: the redirect is held, with all outputs frozen. It takes effect in the first cycle dmem_ready=1, because EX inputs are frozen and still present.
- lu + iwait in the same cycle: outputs are identical; the state goes to IWAIT.
- TIMEOUT=255: stall_timeout rises in the cycle after the 255th consecutive stall cycle.

## Structure
- Shared package `pipe_pkg`:
  - state enum (RUN, DWAIT, IWAIT)
  - REG_W
  - the zero-register constant
- One natural sub-module, `hazard_detect`: purely combinational lu/dwait/iwait comparison.
- FSM, priority mux and counters live in `hazard_ctrl`.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → exactly one cycle of PCWrite=0, ifid_write=0, idex_flush=1; stall_cycles=1.
- Redirect: ex_redirect=1 during a running stream → same cycle PCWrite=1, npc_sel=1, ifid_flush=idex_flush=1; the next cycle is plain RUN.
- Data wait: mem_req=1, dmem_ready=0 for 3 cycles with ex_redirect=1 → pipe_hold=1 and PCWrite=0 for 3 cycles, then the redirect fires on the 4th cycle.
- Fetch wait: imem_ready=0 for 4 cycles → 4 bubbles via idex_flush, state IWAIT, stall_cycles=4; ex_rd=0 with a matching rs never stalls.
- Watchdog: TIMEOUT=4, hold dmem_ready=0 for 6 cycles → stall_timeout rises after cycle 4, stays 1 after ready returns, clears only on reset.
- Reset mid-DWAIT: assert reset for 1 cycle → next cycle RUN outputs, stall_cycles=0, stall_timeout=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing logic: controller states,
// register-index width and the hard-wired zero register.
package pipe_pkg;

   localparam int REG_W = 5;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      IWAIT = 2'd2
   } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the sequencing
// controller (slave): decode/execute fields and memory ready lines in, enables out.
interface hazard_ctrl_if #(
   parameter int REG_W = 5
);
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [REG_W-1:0] ex_rd;
   logic             ex_mem_read;
   logic             ex_redirect;
   logic             imem_ready;
   logic             mem_req;
   logic             dmem_ready;

   logic             PCWrite;
   logic             npc_sel;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_hold;
   logic             stall_timeout;
   logic [31:0]      stall_cycles;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_redirect, imem_ready, mem_req, dmem_ready,
      input  PCWrite, npc_sel, ifid_write, ifid_flush, idex_flush, pipe_hold,
             stall_timeout, stall_cycles
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
             ex_redirect, imem_ready, mem_req, dmem_ready,
      output PCWrite, npc_sel, ifid_write, ifid_flush, idex_flush, pipe_hold,
             stall_timeout, stall_cycles
   );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Purely combinational hazard conditions: load-use match against the EX
// destination, outstanding data access, and outstanding instruction fetch.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] i_id_rs1,
   input  logic [REG_W-1:0] i_id_rs2,
   input  logic             i_id_use_rs1,
   input  logic             i_id_use_rs2,
   input  logic [REG_W-1:0] i_ex_rd,
   input  logic             i_ex_mem_read,
   input  logic             i_imem_ready,
   input  logic             i_mem_req,
   input  logic             i_dmem_ready,
   output logic             o_lu,
   output logic             o_dwait,
   output logic             o_iwait
);
   import pipe_pkg::*;

   localparam logic [REG_W-1:0] W_ZERO = REG_W'(ZERO_REG);

   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
   assign w_rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

   // Writes to the zero register are discarded, so they never feed a consumer.
   assign o_lu    = i_ex_mem_read && (i_ex_rd != W_ZERO) && (w_rs1_hit || w_rs2_hit);
   assign o_dwait = i_mem_req && !i_dmem_ready;
   assign o_iwait = !i_imem_ready;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: resolves data waits, EX redirects,
// load-use and fetch waits into PC/IF/ID/EX enables, plus stall statistics.
module hazard_ctrl #(
   parameter int REG_W   = pipe_pkg::REG_W,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave bus
);
   import pipe_pkg::*;

   localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             w_lu;
   logic             w_dwait;
   logic             w_iwait;

   state_t           r_state;
   state_t           w_state_next;

   logic             w_pc_write;
   logic             w_npc_sel;
   logic             w_ifid_write;
   logic             w_ifid_flush;
   logic             w_idex_flush;
   logic             w_pipe_hold;

   logic [CNT_W-1:0] r_stall_run;
   logic [CNT_W-1:0] w_stall_run_next;
   logic             r_timeout;
   logic [31:0]      r_stall_cycles;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_detect (
      .i_id_rs1      (bus.id_rs1),
      .i_id_rs2      (bus.id_rs2),
      .i_id_use_rs1  (bus.id_use_rs1),
      .i_id_use_rs2  (bus.id_use_rs2),
      .i_ex_rd       (bus.ex_rd),
      .i_ex_mem_read (bus.ex_mem_read),
      .i_imem_ready  (bus.imem_ready),
      .i_mem_req     (bus.mem_req),
      .i_dmem_ready  (bus.dmem_ready),
      .o_lu          (w_lu),
      .o_dwait       (w_dwait),
      .o_iwait       (w_iwait)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_pc_write   = 1'b1;
      w_npc_sel    = 1'b0;
      w_ifid_write = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_flush = 1'b0;
      w_pipe_hold  = 1'b0;
      w_state_next = RUN;

      if (reset) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_dwait) begin
         // EX inputs stay frozen, so a coincident redirect re-presents itself once memory is ready.
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_pipe_hold  = 1'b1;
         w_state_next = DWAIT;
      end else if (bus.ex_redirect) begin
         w_npc_sel    = 1'b1;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_lu || w_iwait) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_idex_flush = 1'b1;
         w_state_next = w_iwait ? IWAIT : RUN;
      end else begin
         unique case (r_state)
            DWAIT, IWAIT: w_state_next = RUN;
            default:      w_state_next = RUN;
         endcase
      end
   end

   always_comb begin
      w_stall_run_next = '0;
      if (!w_pc_write) begin
         w_stall_run_next = (r_stall_run == CNT_MAX) ? r_stall_run : r_stall_run + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_run    <= '0;
         r_timeout      <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_stall_run <= w_stall_run_next;
         if (w_stall_run_next >= TO_V) begin
            r_timeout <= 1'b1;
         end
         if (!w_pc_write) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
      end
   end

   assign bus.PCWrite       = w_pc_write;
   assign bus.npc_sel       = w_npc_sel;
   assign bus.ifid_write    = w_ifid_write;
   assign bus.ifid_flush    = w_ifid_flush;
   assign bus.idex_flush    = w_idex_flush;
   assign bus.pipe_hold     = w_pipe_hold;
   assign bus.stall_timeout = r_timeout;
   assign bus.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, hand-written multi-cycle sequences,
// then random stimulus against a priority-rule reference model.
module tb_hazard_ctrl;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_W(5)) bus ();

   hazard_ctrl #(
      .REG_W   (5),
      .TIMEOUT (TO),
      .CNT_W   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       rst;
      logic       mem_req;
      logic       dmem_ready;
      logic       redirect;
      logic       mem_read;
      logic [4:0] ex_rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic       imem_ready;
   } in_t;

   // Expected enables packed as {PCWrite, npc_sel, ifid_write, ifid_flush, idex_flush, pipe_hold}.
   typedef struct {
      in_t        in;
      logic [5:0] exp;
      string      name;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   int          m_run = 0;
   bit          m_to  = 1'b0;
   int unsigned m_cycles = 0;

   vec_t        tbl[14];

   function automatic in_t mk(bit rst, bit mreq, bit dr, bit redir, bit mrd,
                              int rd, int r1, int r2, bit u1, bit u2, bit ir);
      in_t t;
      t.rst        = rst;
      t.mem_req    = mreq;
      t.dmem_ready = dr;
      t.redirect   = redir;
      t.mem_read   = mrd;
      t.ex_rd      = 5'(rd);
      t.rs1        = 5'(r1);
      t.rs2        = 5'(r2);
      t.use1       = u1;
      t.use2       = u2;
      t.imem_ready = ir;
      return t;
   endfunction

   function automatic logic [5:0] model_out(in_t x);
      bit lu;
      lu = x.mem_read && (x.ex_rd != 0) &&
           ((x.use1 && x.rs1 == x.ex_rd) || (x.use2 && x.rs2 == x.ex_rd));
      if (x.rst)                              return 6'b000110;
      if (x.mem_req && !x.dmem_ready)         return 6'b000001;
      if (x.redirect)                         return 6'b111110;
      if (lu || !x.imem_ready)                return 6'b000010;
      return 6'b101000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t x);
      reset           = x.rst;
      bus.mem_req     = x.mem_req;
      bus.dmem_ready  = x.dmem_ready;
      bus.ex_redirect = x.redirect;
      bus.ex_mem_read = x.mem_read;
      bus.ex_rd       = x.ex_rd;
      bus.id_rs1      = x.rs1;
      bus.id_rs2      = x.rs2;
      bus.id_use_rs1  = x.use1;
      bus.id_use_rs2  = x.use2;
      bus.imem_ready  = x.imem_ready;
   endtask

   // One clock: drive, compare enables and counters, then advance the model past the edge.
   task automatic step(input in_t x, input string tag, input bit use_exp, input logic [5:0] texp);
      logic [5:0] outs;
      logic [5:0] e;
      @(negedge clk);
      drive(x);
      #1;
      e    = use_exp ? texp : model_out(x);
      outs = {bus.PCWrite, bus.npc_sel, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.pipe_hold};
      $display("txn %s enables=%b cycles=%0d timeout=%0b", tag, outs, bus.stall_cycles, bus.stall_timeout);
      chk({tag, "/enables"}, 32'(outs), 32'(e));
      chk({tag, "/stall_cycles"}, bus.stall_cycles, m_cycles);
      chk({tag, "/timeout"}, 32'(bus.stall_timeout), 32'(m_to));
      if (x.rst) begin
         m_run    = 0;
         m_to     = 1'b0;
         m_cycles = 0;
      end else if (!e[5]) begin
         m_run    = (m_run < 255) ? m_run + 1 : 255;
         m_cycles = m_cycles + 1;
         if (m_run >= TO) m_to = 1'b1;
      end else begin
         m_run = 0;
      end
   endtask

   in_t run_v, rst_v, dw_v, dwr_v, iw_v;

   initial begin
      run_v = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      rst_v = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      dw_v  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      dwr_v = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      iw_v  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      tbl[0]  = '{rst_v, 6'b000110, "t_reset"};
      tbl[1]  = '{run_v, 6'b101000, "t_run"};
      tbl[2]  = '{mk(0, 0, 1, 0, 1, 5, 0, 5, 0, 1, 1), 6'b000010, "t_lu_rs2"};
      tbl[3]  = '{mk(0, 0, 1, 0, 1, 7, 7, 0, 1, 0, 1), 6'b000010, "t_lu_rs1"};
      tbl[4]  = '{mk(0, 0, 1, 0, 1, 5, 5, 5, 0, 0, 1), 6'b101000, "t_match_unused"};
      tbl[5]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1), 6'b101000, "t_rd_zero"};
      tbl[6]  = '{mk(0, 0, 1, 0, 0, 5, 5, 0, 1, 0, 1), 6'b101000, "t_not_load"};
      tbl[7]  = '{iw_v, 6'b000010, "t_iwait"};
      tbl[8]  = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 6'b111110, "t_redir_iwait"};
      tbl[9]  = '{mk(0, 0, 1, 1, 1, 5, 5, 0, 1, 0, 1), 6'b111110, "t_redir_lu"};
      tbl[10] = '{mk(0, 1, 0, 1, 1, 5, 5, 0, 1, 0, 0), 6'b000001, "t_dwait_all"};
      tbl[11] = '{mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1), 6'b101000, "t_mem_ready"};
      tbl[12] = '{mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1), 6'b000110, "t_reset_dwait"};
      tbl[13] = '{run_v, 6'b101000, "t_run_after_reset"};

      // Unchecked reset so the counters have a known value before comparisons start.
      drive(rst_v);
      @(negedge clk);
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].in, tbl[i].name, 1'b1, tbl[i].exp);
      end

      // Load-use for one cycle: a single bubble.
      step(rst_v, "lu_rst", 1'b0, '0);
      step(mk(0, 0, 1, 0, 1, 5, 0, 5, 0, 1, 1), "lu_hit", 1'b1, 6'b000010);
      step(run_v, "lu_after", 1'b1, 6'b101000);
      chk("lu_stall_cycles", bus.stall_cycles, 32'd1);

      // Redirect inside a running stream, followed by plain RUN.
      step(run_v, "br_pre", 1'b0, '0);
      step(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1), "br_taken", 1'b1, 6'b111110);
      step(run_v, "br_post", 1'b1, 6'b101000);

      // Data wait with a pending redirect: three held cycles, redirect on the fourth.
      for (int i = 0; i < 3; i++) step(dwr_v, "dw_redir_hold", 1'b1, 6'b000001);
      step(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), "dw_redir_fire", 1'b1, 6'b111110);
      step(run_v, "dw_redir_post", 1'b1, 6'b101000);

      // Fetch wait of four cycles.
      step(rst_v, "iw_rst", 1'b0, '0);
      for (int i = 0; i < 4; i++) step(iw_v, "iw_wait", 1'b1, 6'b000010);
      step(mk(0, 0, 1, 0, 1, 0, 3, 0, 1, 0, 1), "iw_done_rd0", 1'b1, 6'b101000);
      chk("iw_stall_cycles", bus.stall_cycles, 32'd4);

      // Watchdog with TIMEOUT=4: six stalled cycles, sticky until reset.
      step(rst_v, "wd_rst", 1'b0, '0);
      for (int i = 0; i < 6; i++) step(dw_v, "wd_dwait", 1'b1, 6'b000001);
      step(run_v, "wd_ready", 1'b1, 6'b101000);
      step(run_v, "wd_ready2", 1'b1, 6'b101000);
      chk("wd_sticky", 32'(bus.stall_timeout), 32'd1);
      step(rst_v, "wd_clear", 1'b0, '0);
      step(run_v, "wd_after", 1'b0, '0);
      chk("wd_cleared", 32'(bus.stall_timeout), 32'd0);

      // Reset in the middle of a data wait.
      step(dw_v, "rm_dwait", 1'b0, '0);
      step(dw_v, "rm_dwait", 1'b0, '0);
      step(rst_v, "rm_reset", 1'b0, '0);
      step(run_v, "rm_run", 1'b1, 6'b101000);
      chk("rm_stall_cycles", bus.stall_cycles, 32'd0);

      // Random stimulus against the reference model.
      for (int n = 0; n < 400; n++) begin
         in_t r;
         r = mk(($urandom_range(39) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1,
                ($urandom_range(7) == 0), ($urandom_range(2) == 0),
                int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                $urandom_range(1) == 1, $urandom_range(1) == 1, ($urandom_range(3) != 0));
         step(r, $sformatf("rnd%0d", n), 1'b0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
